// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM link (receive demux and future transmit mux).
package tdm_pkg;

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } tdm_state_e;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

    localparam int unsigned TDM_CH = 4;

endpackage

// File: rtl/tdm_slot_ctr.sv
// 2-bit slot index counter; clr has priority over load1, load1 over inc.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load1,
    input  logic       inc,
    output logic [1:0] slot
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= SLOT_A;
        end else if (clr) begin
            slot <= SLOT_A;
        end else if (load1) begin
            slot <= SLOT_B;
        end else if (inc) begin
            slot <= slot + 2'd1;
        end
    end

endmodule

// File: rtl/demux14_tdm.sv
// Four-slot TDM receive demux: frames on fsync, collects slots a..d, and
// publishes them together as one aligned frame.
module demux14_tdm
    import tdm_pkg::*;
#(
    parameter int unsigned W        = 1,
    parameter int unsigned MISS_MAX = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_vld,
    input  logic         fsync,
    output logic [W-1:0] ya,
    output logic [W-1:0] yb,
    output logic [W-1:0] yc,
    output logic [W-1:0] yd,
    output logic         frame_vld,
    output logic         locked,
    output logic [1:0]   slot,
    output logic         sync_err
);

    localparam logic [2:0] MissLimit = 3'(MISS_MAX);

    tdm_state_e   state_q, state_d;
    logic [2:0]   miss_q, miss_d;
    logic [W-1:0] sh0_q, sh0_d;
    logic [W-1:0] sh1_q, sh1_d;
    logic [W-1:0] sh2_q, sh2_d;
    logic         frame_d;
    logic         err_d;
    logic         ctr_clr;
    logic         ctr_load1;
    logic         ctr_inc;

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clr),
        .load1 (ctr_load1),
        .inc   (ctr_inc),
        .slot  (slot)
    );

    always_comb begin
        state_d   = state_q;
        miss_d    = miss_q;
        sh0_d     = sh0_q;
        sh1_d     = sh1_q;
        sh2_d     = sh2_q;
        frame_d   = 1'b0;
        err_d     = 1'b0;
        ctr_clr   = 1'b0;
        ctr_load1 = 1'b0;
        ctr_inc   = 1'b0;

        if (din_vld) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (fsync) begin
                        sh0_d     = din;
                        ctr_load1 = 1'b1;
                        miss_d    = 3'd0;
                        state_d   = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (slot == SLOT_A) begin
                        if (fsync) begin
                            sh0_d     = din;
                            ctr_load1 = 1'b1;
                            miss_d    = 3'd0;
                        end else if (miss_q + 3'd1 == MissLimit) begin
                            state_d = ST_HUNT;
                            ctr_clr = 1'b1;
                            miss_d  = 3'd0;
                        end else begin
                            sh0_d     = din;
                            ctr_load1 = 1'b1;
                            miss_d    = miss_q + 3'd1;
                        end
                    end else if (fsync) begin
                        // Early marker: drop the partial frame and restart at slot 0.
                        err_d     = 1'b1;
                        sh0_d     = din;
                        ctr_load1 = 1'b1;
                        miss_d    = 3'd0;
                    end else begin
                        case (slot)
                            SLOT_B: begin
                                sh1_d   = din;
                                ctr_inc = 1'b1;
                            end
                            SLOT_C: begin
                                sh2_d   = din;
                                ctr_inc = 1'b1;
                            end
                            default: begin
                                frame_d = 1'b1;
                                ctr_clr = 1'b1;
                            end
                        endcase
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HUNT;
            miss_q    <= 3'd0;
            sh0_q     <= '0;
            sh1_q     <= '0;
            sh2_q     <= '0;
            ya        <= '0;
            yb        <= '0;
            yc        <= '0;
            yd        <= '0;
            frame_vld <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            miss_q    <= miss_d;
            sh0_q     <= sh0_d;
            sh1_q     <= sh1_d;
            sh2_q     <= sh2_d;
            frame_vld <= frame_d;
            sync_err  <= err_d;
            if (frame_d) begin
                ya <= sh0_q;
                yb <= sh1_q;
                yc <= sh2_q;
                yd <= din;
            end
        end
    end

    assign locked = (state_q == ST_LOCK);

endmodule

// File: doc/demux14_tdm.md
# demux14_tdm

Four-channel time-division demultiplexer: accepts a slot-interleaved stream, one sample per `din_vld`, with a frame marker on slot 0. It distributes slots 0..3 to parallel outputs `ya..yd` and presents all four as one aligned frame. It is the receive end of a 4:1 select path, where slot code 0..3 maps to a..d. It sits between a 4:1 TDM transmitter (or serial link) and per-channel consumers.

## Interface
- `W`, default 1: sample width per slot.
- `MISS_MAX`, default 2: number of consecutive slot-0 samples without `fsync` tolerated in LOCK before returning to HUNT; legal range 1..7.
- `CLK`  in  1  single clock; all state changes on rising edge.
- `RST_N`  in  1  reset, asynchronous assert, active-low; released synchronously by the integrator.
- `din`  in  W  slot sample.
- `din_vld`  in  1  `din` valid this cycle; gaps of any length are allowed.
- `fsync`  in  1  frame marker; meaningful only when `din_vld`=1; marks the slot-0 sample.
- `ya`, `yb`, `yc`, `yd`  out  W  slot 0/1/2/3 of the last complete frame; registered.
- `frame_vld`  out  1  one-cycle pulse: `ya..yd` updated this cycle.
- `locked`  out  1  the state is LOCK.
- `slot`  out  2  slot index the next accepted sample will fill.
- `sync_err`  out  1  one-cycle pulse: `fsync` arrived at a nonzero slot.

## Operation
- Reset values: `ya..yd`=0, `frame_vld`=0, `locked`=0, `slot`=0, `sync_err`=0, state HUNT, miss count 0, shadow registers 0.
- HUNT:
  - `din_vld` without `fsync`: sample discarded.
  - `din_vld & fsync`: `din` goes to `sh0`, `slot`→1, state goes to LOCK, miss count→0.
- LOCK, on each `din_vld`:
  - slot 0, `fsync`=1: store to `sh0`, `slot`→1, miss count→0.
  - slot 0, `fsync`=0: store to `sh0`, `slot`→1, miss count +1. If the new count equals `MISS_MAX`, state goes to HUNT, `slot`→0, and the sample is discarded.
  - slot 1 or 2: store to `sh1`/`sh2`, `slot`+1; `fsync`=0 required.
  - slot 3: `fsync`=0. Next cycle: `ya`=`sh0`, `yb`=`sh1`, `yc`=`sh2`, `yd`=`din`, `frame_vld`=1, `slot`→0.
  - Any nonzero slot with `fsync`=1: `sync_err` pulses next cycle. The partial frame is discarded (no `frame_vld`). The sample is taken as slot 0 (`sh0`=`din`, `slot`→1), and miss count→0. State stays LOCK.
- `slot` wraps 3→0 only on an accepted slot-3 sample or on a HUNT transition.
- Outputs `ya..yd` hold their values between frames and are never partially updated.
- `RST_N` asserted mid-frame: immediate return to reset values; the partial frame is lost.

## Timing
- Latency: the slot-3 sample accepted at edge n gives `ya..yd` and `frame_vld` valid after edge n+1, which is 1 cycle.
- `sync_err` is registered, 1 cycle after the offending sample. It never coincides with `frame_vld` for the same sample.
- Back-to-back frames at full rate (`din_vld` held at 1) produce `frame_vld` every 4th cycle with no bubbles.
- `locked` rises the cycle after the first accepted `fsync` sample. It falls the cycle after the `MISS_MAX`-th miss.
- `din`/`fsync` are ignored whenever `din_vld`=0, and no state advances.

## Structure
- Shared package `tdm_pkg` holds:
  - state enum `{ST_HUNT, ST_LOCK}`;
  - slot constants `SLOT_A`=2'd0, `SLOT_B`=2'd1, `SLOT_C`=2'd2, `SLOT_D`=2'd3;
  - `TDM_CH`=4. The future 4:1 transmitter reuses the same package.
- One sub-module, `tdm_slot_ctr`: a 2-bit slot counter with `clr`, `load1`, and `inc` enables and asynchronous active-low reset. The FSM, miss counter (3 bits), and shadow/output registers stay in the top level.

## Test plan
- Reset, then with `W`=4, `din_vld`=1: sequence {`fsync`,0x1},{0x2},{0x3},{0x4} → one cycle later `ya..yd`=1,2,3,4, `frame_vld`=1 for one cycle, `locked`=1.
- Samples 0x5,0x6 without `fsync` while in HUNT → no output change, `locked`=0, `slot`=0.
- Full-rate 3 frames with `din_vld` gaps of 0–3 cycles inserted randomly → three `frame_vld` pulses with correct values, and `ya..yd` unchanged between pulses.
- In LOCK, `fsync` at slot 2 with `din`=0x9 → `sync_err` pulse, no `frame_vld`, next 3 samples 0xA,0xB,0xC → frame 9,A,B,C.
- `MISS_MAX`=2: two frames with `fsync` withheld → first frame delivered normally; second slot-0 miss → `locked`=0, `slot`=0, and no `frame_vld` for that frame.
- `RST_N` asserted after slot 1 of a frame → all outputs 0 immediately and state HUNT; after release, the next `fsync` frame is delivered correctly.
